// File: rtl/chebyshev_pkg.sv
// Shared types and defaults for the chebyshev kernel call driver.
// Holds the FSM encoding, the default widths and the issue-credit check.
package chebyshev_pkg;

    localparam int unsigned IDX_W_DEF        = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned MAX_INFLIGHT_DEF = 8;
    localparam int unsigned ACC_W_DEF        = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_REPORT
    } state_e;

    // A call may issue only while every outstanding result still has a FIFO slot.
    function automatic logic credit_ok(input int unsigned inflight,
                                       input int unsigned max_inflight);
        return inflight < max_inflight;
    endfunction

endpackage

// File: rtl/chebyshev_res_fifo.sv
// Purpose: in-order synchronous result FIFO, DEPTH entries of WIDTH bits.
// Latency: a pushed word appears at dout/!empty one cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; full/empty/count are registered.
module chebyshev_res_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/chebyshev_call_driver.sv
// Purpose: sequence count kernel calls at base+i*stride, stream results in order, report their sum.
// Latency: first call one cycle after command accept; each result visible one cycle after its return.
// Backpressure: calls capped at MAX_INFLIGHT unpopped results; k_stall raised while the result FIFO is full.
module chebyshev_call_driver
    import chebyshev_pkg::*;
#(
    parameter int unsigned IDX_W        = IDX_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int unsigned ACC_W        = ACC_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDX_W-1:0]  cmd_base,
    input  logic [IDX_W-1:0]  cmd_stride,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              k_start,
    input  logic              k_busy,
    output logic [IDX_W-1:0]  k_idx,
    input  logic              k_done,
    output logic              k_stall,
    input  logic [DATA_W-1:0] k_returndata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_last,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum_data,
    output logic [CNT_W-1:0]  sum_count,
    output logic              stray_ret
);

    localparam int unsigned CW = $clog2(MAX_INFLIGHT) + 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    stride_q, stride_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    recv_q, recv_d;
    logic [CNT_W-1:0]    popped_q, popped_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                stray_q, stray_d;

    logic [CNT_W-1:0]    inflight;
    logic                ret_push;
    logic                res_pop;
    logic [ACC_W-1:0]    ret_ext;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_cnt;
    logic [DATA_W-1:0]   fifo_dout;

    chebyshev_res_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (DATA_W)
    ) u_res_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (ret_push),
        .din    (k_returndata),
        .pop    (res_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    // Outstanding = issued but not yet popped, so FIFO space is reserved at issue time.
    assign inflight  = issued_q - popped_q;
    assign ret_ext   = {{(ACC_W-DATA_W){k_returndata[DATA_W-1]}}, k_returndata};

    assign k_idx     = idx_q;
    assign k_stall   = fifo_full;
    assign res_valid = !fifo_empty;
    assign res_data  = fifo_dout;
    assign res_last  = res_valid && (popped_q == count_q - CNT_W'(1));
    assign res_pop   = res_valid && res_ready;
    assign sum_valid = (state_q == ST_REPORT);
    assign sum_data  = acc_q;
    assign sum_count = recv_q;
    assign stray_ret = stray_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stride_d  = stride_q;
        count_d   = count_q;
        issued_d  = issued_q;
        recv_d    = recv_q;
        popped_d  = popped_q;
        acc_d     = acc_q;
        stray_d   = 1'b0;
        cmd_ready = 1'b0;
        k_start   = 1'b0;
        ret_push  = 1'b0;

        if (res_pop) begin
            popped_d = popped_q + CNT_W'(1);
        end

        if ((state_q == ST_ISSUE || state_q == ST_DRAIN) && k_done && !k_stall) begin
            ret_push = 1'b1;
            recv_d   = recv_q + CNT_W'(1);
            acc_d    = acc_q + ret_ext;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                stray_d   = k_done;
                if (cmd_valid) begin
                    idx_d    = cmd_base;
                    stride_d = cmd_stride;
                    count_d  = cmd_count;
                    issued_d = '0;
                    recv_d   = '0;
                    popped_d = '0;
                    acc_d    = '0;
                    state_d  = (cmd_count == '0) ? ST_REPORT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                k_start = credit_ok(32'(inflight), MAX_INFLIGHT);
                if (k_start && !k_busy) begin
                    idx_d    = idx_q + stride_q;
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q + CNT_W'(1) == count_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (res_pop && res_last && recv_q == count_q) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            stride_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            popped_q <= '0;
            acc_q    <= '0;
            stray_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            popped_q <= popped_d;
            acc_q    <= acc_d;
            stray_q  <= stray_d;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(ret_push && fifo_full) && (fifo_cnt <= CW'(MAX_INFLIGHT)));

endmodule

// File: tb/tb_chebyshev_call_driver.sv
// Scoreboard bench for chebyshev_call_driver: a behavioural kernel answers each call one cycle later,
// expected results are queued at issue time and compared as the result stream pops them.
module tb_chebyshev_call_driver;

    logic        clock;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_base;
    logic [31:0] cmd_stride;
    logic [15:0] cmd_count;
    logic        k_start;
    logic        k_busy;
    logic [31:0] k_idx;
    logic        k_done;
    logic        k_stall;
    logic [31:0] k_returndata;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic        sum_valid;
    logic [47:0] sum_data;
    logic [15:0] sum_count;
    logic        stray_ret;

    chebyshev_call_driver dut (
        .clock        (clock),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_stride   (cmd_stride),
        .cmd_count    (cmd_count),
        .k_start      (k_start),
        .k_busy       (k_busy),
        .k_idx        (k_idx),
        .k_done       (k_done),
        .k_stall      (k_stall),
        .k_returndata (k_returndata),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_last     (res_last),
        .sum_valid    (sum_valid),
        .sum_data     (sum_data),
        .sum_count    (sum_count),
        .stray_ret    (stray_ret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pend_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] exp_idx, exp_stride;
    logic [47:0] exp_sum, last_sum;
    int          cur_count, calls_seen, pop_idx, sum_pulses, busy_left;
    bit          cmd_pend, ret_neg, rr_en;
    logic [31:0] nb, ns;
    logic [15:0] nc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the kernel/consumer model: drive at negedge, then score the transfers
    // that the following posedge will complete.
    task automatic step();
        logic [31:0] d;
        @(negedge clock);
        cmd_valid    = cmd_pend;
        cmd_base     = nb;
        cmd_stride   = ns;
        cmd_count    = nc;
        k_busy       = k_start && (calls_seen == 1) && (busy_left > 0);
        if (k_busy) busy_left--;
        k_done       = (pend_q.size() > 0);
        k_returndata = k_done ? pend_q[0] : 32'h0;
        res_ready    = rr_en;
        #1;
        if (cmd_valid && cmd_ready) begin
            cmd_pend   = 1'b0;
            exp_idx    = nb;
            exp_stride = ns;
            cur_count  = int'(nc);
            calls_seen = 0;
            pop_idx    = 0;
            exp_sum    = '0;
        end
        if (k_start && k_busy) chk("k_idx_hold", k_idx, exp_idx);
        if (k_start && !k_busy) begin
            chk("call_in_range", calls_seen < cur_count, 1);
            chk("k_idx", k_idx, exp_idx);
            d = ret_neg ? 32'hFFFF_FFFF : (exp_idx << 1);
            pend_q.push_back(d);
            sb_q.push_back(d);
            exp_sum    = exp_sum + {{16{d[31]}}, d};
            exp_idx    = exp_idx + exp_stride;
            calls_seen++;
        end
        if (k_done && !k_stall) pend_q.delete(0);
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                chk("res_data", res_data, sb_q.pop_front());
                chk("res_last", res_last, pop_idx == cur_count - 1);
                pop_idx++;
            end
        end
        if (sum_valid) begin
            sum_pulses++;
            last_sum = sum_data;
            chk("sum_data", sum_data, exp_sum);
            chk("sum_count", sum_count, cur_count);
        end
    endtask

    task automatic start_cmd(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
        nb       = b;
        ns       = s;
        nc       = c;
        cmd_pend = 1'b1;
    endtask

    task automatic wait_sum(input int budget, input int count);
        int start = sum_pulses;
        int n = 0;
        while (sum_pulses == start && n < budget) begin
            step();
            n++;
        end
        chk("sum_pulse_seen", sum_pulses - start, 1);
        step();
        chk("cmd_ready_back", cmd_ready, 1);
        chk("sum_once", sum_pulses - start, 1);
        chk("sb_empty", sb_q.size(), 0);
        chk("calls_issued", calls_seen, count);
        chk("results_popped", pop_idx, count);
    endtask

    task automatic chk_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_k_start", k_start, 0);
        chk("rst_k_idx", k_idx, 0);
        chk("rst_k_stall", k_stall, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum_data", sum_data, 0);
        chk("rst_sum_count", sum_count, 0);
        chk("rst_stray_ret", stray_ret, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_count = '0;
        k_busy = 1'b0; k_done = 1'b0; k_returndata = '0; res_ready = 1'b0;
        nb = '0; ns = '0; nc = '0; cmd_pend = 1'b0; ret_neg = 1'b0; rr_en = 1'b1;
        exp_idx = '0; exp_stride = '0; exp_sum = '0; last_sum = '0;
        cur_count = 0; calls_seen = 0; pop_idx = 0; sum_pulses = 0; busy_left = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk_reset();

        // 1: simple run, results idx*2
        start_cmd(32'd0, 32'd1, 16'd4);
        wait_sum(200, 4);
        chk("t1_sum", last_sum, 48'd12);
        repeat (2) step();

        // 2: empty command
        start_cmd(32'd5, 32'd1, 16'd0);
        wait_sum(50, 0);
        chk("t2_sum", last_sum, 48'd0);
        repeat (2) step();

        // 3: consumer stalled, credit limit holds issue at 8
        rr_en = 1'b0;
        start_cmd(32'd0, 32'd1, 16'd20);
        repeat (30) step();
        chk("t3_calls_capped", calls_seen, 8);
        chk("t3_k_start_low", k_start, 0);
        chk("t3_k_stall_high", k_stall, 1);
        rr_en = 1'b1;
        wait_sum(400, 20);
        repeat (2) step();

        // 4: kernel busy on the second call
        busy_left = 5;
        start_cmd(32'd100, 32'd3, 16'd5);
        wait_sum(200, 5);
        chk("t4_busy_consumed", busy_left, 0);
        repeat (2) step();

        // 5: index wrap and negative results
        ret_neg = 1'b1;
        start_cmd(32'hFFFF_FFFE, 32'd1, 16'd4);
        wait_sum(200, 4);
        chk("t5_sum", last_sum, 48'hFFFF_FFFF_FFFC);
        ret_neg = 1'b0;
        repeat (2) step();

        // 6: reset while draining, then a stray return, then a clean command
        begin
            int n = 0;
            start_cmd(32'd0, 32'd1, 16'd6);
            while (calls_seen < 6 && n < 100) begin
                step();
                n++;
            end
            chk("t6_reached_drain", calls_seen, 6);
        end
        @(negedge clock);
        resetn = 1'b0; cmd_valid = 1'b0; k_done = 1'b0; k_busy = 1'b0; res_ready = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk_reset();
        pend_q.delete();
        sb_q.delete();
        pend_q.push_back(32'h1234);
        step();
        step();
        chk("t6_stray_pulse", stray_ret, 1);
        chk("t6_no_result", res_valid, 0);
        step();
        chk("t6_stray_clear", stray_ret, 0);
        start_cmd(32'd8, 32'd2, 16'd3);
        wait_sum(100, 3);
        chk("t6_sum", last_sum, 48'd60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
